line_mem: RTL and testbench

//  Parametrised backing memory for the set-associative cache: word-granular

---
 rtl/line_mem.sv | 88 ++++++++
 tb/tb_line_mem.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/line_mem.sv
// line_mem: line-read / byte-enable word-write backing memory with clear sweep
// Ports: clk, reset (async, active low); cs, clr; req_valid/req_ready/req_rw/
// req_addr/req_wdata/req_be request channel; rsp_valid/rsp_ready/rsp_data held
// response channel (lowest address in the MSB word); busy = FSM not in IDLE.
module line_mem #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 6,
   parameter int LINE_WORDS     = 4,
   parameter int RD_LAT         = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cs,
   input  logic                         clr,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_rw,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_wdata,
   input  logic [DATA_W/8-1:0]          req_be,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [LINE_WORDS*DATA_W-1:0] rsp_data,
   output logic                         busy
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   typedef enum logic [2:0] {INIT, IDLE, RD_WAIT, RESP, CLEAR} state_t;
   state_t state, state_nx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [CW-1:0] cnt;
   logic [ADDR_W-1:0] idx, base;
   logic [LINE_WORDS*DATA_W-1:0] line;
   logic acc, clr_go, rd_done;
   assign req_ready = cs & (state == IDLE) & ~clr;
   assign acc       = req_valid & req_ready;
   assign clr_go    = cs & clr & (state == IDLE);
   assign rd_done   = (state == RD_WAIT) && (cnt == '0);
   assign busy      = (state != IDLE);
   // base is line aligned, so OR-ing the word offset never carries across lines
   for (genvar w = 0; w < LINE_WORDS; w++) begin : g_line
      assign line[(LINE_WORDS-1-w)*DATA_W +: DATA_W] = mem[base | ADDR_W'(w)];
   end
   always_comb begin
      state_nx = (state == INIT)    ? ((CLEAR_ON_RESET != 0) ? CLEAR : IDLE)
               : (state == IDLE)    ? (clr_go ? CLEAR : (acc && !req_rw) ? RD_WAIT : IDLE)
               : (state == RD_WAIT) ? ((cnt == '0) ? RESP : RD_WAIT)
               : (state == RESP)    ? (rsp_ready ? IDLE : RESP)
               : (state == CLEAR)   ? ((idx == '1) ? IDLE : CLEAR)
               : INIT;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= INIT;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         idx       <= '0;
         base      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (acc && !req_rw && !clr_go) begin
            base <= req_addr & ~ADDR_W'(LINE_WORDS-1);
            cnt  <= CW'(RD_LAT-1);
         end else if (state == RD_WAIT) begin
            cnt <= cnt - 1'b1;
         end
         // idx wraps to 0 after the last word, ready for the next sweep
         if (state == CLEAR) idx <= idx + 1'b1;
         if (rd_done) begin
            rsp_data  <= line;
            rsp_valid <= 1'b1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
   // array has no reset; only the sweep zeroes it
   always_ff @(posedge clk) begin
      if (state == CLEAR) mem[idx] <= '0;
      else if (acc && req_rw)
         for (int b = 0; b < DATA_W/8; b++)
            if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
   end
endmodule

// File: tb/tb_line_mem.sv
// tb_line_mem: directed scoreboard bench for line_mem (clear-on-reset and no-clear instances)
module tb_line_mem;
   localparam int DW = 32, AW = 6, LW = 4, RL = 2;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, reset1, cs, clr, req_valid, req_valid1, req_rw, rsp_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [3:0] req_be;
   logic rr0, rr1, rv0, rv1, b0, b1;
   logic [127:0] rd0, rd1;
   int passed = 0, failed = 0, total = 0;
   logic [31:0] model [2][64];
   logic [127:0] sbq [$];
   line_mem #(.DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .RD_LAT(RL), .CLEAR_ON_RESET(1)) u0 (
      .clk(clk), .reset(reset), .cs(cs), .clr(clr), .req_valid(req_valid), .req_ready(rr0),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .busy(b0));
   line_mem #(.DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .RD_LAT(RL), .CLEAR_ON_RESET(0)) u1 (
      .clk(clk), .reset(reset1), .cs(cs), .clr(clr), .req_valid(req_valid1), .req_ready(rr1),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .busy(b1));
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [127:0] mline(input bit s, input logic [5:0] a);
      logic [5:0] bs;
      bs = {a[5:2], 2'b00};
      return {model[s][bs], model[s][bs+6'd1], model[s][bs+6'd2], model[s][bs+6'd3]};
   endfunction
   task automatic wait_ready(input bit s, input string tag);
      for (int i = 0; i < 300 && !(s ? rr1 : rr0); i++) step();
      chk(tag, 128'(s ? rr1 : rr0), 128'd1);
   endtask
   task automatic wr(input bit s, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      req_rw = 1'b1; req_addr = a; req_wdata = d; req_be = be;
      if (s) req_valid1 = 1'b1; else req_valid = 1'b1;
      wait_ready(s, "wr_ready");
      step();
      req_valid = 1'b0; req_valid1 = 1'b0;
      for (int b = 0; b < 4; b++) if (be[b]) model[s][a][8*b +: 8] = d[8*b +: 8];
   endtask
   task automatic rd(input bit s, input logic [5:0] a, input int hold, input string tag);
      logic [127:0] exp;
      int n;
      sbq.push_back(mline(s, a));
      req_rw = 1'b0; req_addr = a;
      if (s) req_valid1 = 1'b1; else req_valid = 1'b1;
      wait_ready(s, {tag, "_ready"});
      step();
      req_valid = 1'b0; req_valid1 = 1'b0;
      n = 0;
      while (!(s ? rv1 : rv0) && n < 20) begin step(); n++; end
      chk({tag, "_lat"}, 128'(n), 128'(RL));
      exp = sbq.pop_front();
      chk(tag, s ? rd1 : rd0, exp);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_valid"}, 128'(s ? rv1 : rv0), 128'd1);
         chk({tag, "_hold_data"}, s ? rd1 : rd0, exp);
         chk({tag, "_hold_ready"}, 128'(s ? rr1 : rr0), 128'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, 128'(s ? rv1 : rv0), 128'd0);
      chk({tag, "_keep"}, s ? rd1 : rd0, exp);
   endtask
   initial begin
      int n;
      reset = 1'b0; reset1 = 1'b0; cs = 1'b1; clr = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
      req_rw = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
      step(); step();
      chk("rst_busy", 128'(b0), 128'd1);
      chk("rst_ready", 128'(rr0), 128'd0);
      chk("rst_valid", 128'(rv0), 128'd0);
      chk("rst_data", rd0, 128'd0);
      reset = 1'b1;
      n = 0;
      while (b0 && n < 200) begin step(); n++; end
      chk("init_clear_cycles", 128'(n), 128'd65);
      chk("idle_ready", 128'(rr0), 128'd1);
      for (int i = 0; i < 64; i++) model[0][i] = '0;
      rd(0, 6'h00, 0, "t1_line0");
      wr(0, 6'd8, 32'h11111111, 4'hF);
      wr(0, 6'd9, 32'h22222222, 4'hF);
      wr(0, 6'd10, 32'h33333333, 4'hF);
      wr(0, 6'd11, 32'h44444444, 4'hF);
      rd(0, 6'h0A, 0, "t2_line8");
      chk("t2_const", rd0, 128'h11111111_22222222_33333333_44444444);
      wr(0, 6'd5, 32'hAABBCCDD, 4'hF);
      wr(0, 6'd5, 32'h00000099, 4'b0001);
      rd(0, 6'd4, 0, "t3_line4");
      chk("t3_word1", 128'(rd0[95:64]), 128'h0AABBCC99);
      rd(0, 6'd9, 5, "t4_hold");
      cs = 1'b0;
      #1;
      chk("cs0_ready", 128'(rr0), 128'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("cs0_clr_ignored", 128'(b0), 128'd0);
      cs = 1'b1;
      #1;
      clr = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 6'd8; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
      #1;
      chk("t5_clr_blocks_ready", 128'(rr0), 128'd0);
      step();
      clr = 1'b0; req_valid = 1'b0;
      n = 1;
      while (b0 && n < 200) begin step(); n++; end
      chk("t5_sweep_cycles", 128'(n), 128'd65);
      for (int i = 0; i < 64; i++) model[0][i] = '0;
      for (int l = 0; l < 16; l++) rd(0, 6'(4*l + 1), 0, "t5_zero");
      step();
      reset1 = 1'b1;
      n = 0;
      while (b1 && n < 20) begin step(); n++; end
      chk("t6_noclear_init", 128'(n), 128'd1);
      wr(1, 6'd16, 32'hCAFE0001, 4'hF);
      wr(1, 6'd17, 32'hCAFE0002, 4'hF);
      wr(1, 6'd18, 32'hCAFE0003, 4'hF);
      wr(1, 6'd19, 32'hCAFE0004, 4'hF);
      req_rw = 1'b0; req_addr = 6'd17; req_valid1 = 1'b1;
      wait_ready(1, "t6_rd_ready");
      step();
      req_valid1 = 1'b0;
      reset1 = 1'b0;
      #1;
      chk("t6_rdwait_rst_valid", 128'(rv1), 128'd0);
      chk("t6_rdwait_rst_busy", 128'(b1), 128'd1);
      step();
      reset1 = 1'b1;
      n = 0;
      while (b1 && n < 20) begin step(); n++; end
      chk("t6_reinit", 128'(n), 128'd1);
      rd(1, 6'd18, 0, "t6_survive");
      req_rw = 1'b0; req_addr = 6'd16; req_valid1 = 1'b1;
      wait_ready(1, "t6b_ready");
      step();
      req_valid1 = 1'b0;
      n = 0;
      while (!rv1 && n < 20) begin step(); n++; end
      chk("t6b_resp", 128'(rv1), 128'd1);
      #2;
      reset1 = 1'b0;
      #1;
      chk("t6b_rst_valid", 128'(rv1), 128'd0);
      chk("t6b_rst_data", rd1, 128'd0);
      step();
      reset1 = 1'b1;
      step();
      rd(1, 6'd19, 0, "t6b_survive");
      chk("sb_empty", 128'(sbq.size()), 128'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
